// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared defaults, round-robin pick and response record for mult_share_arb
package mult_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);
  localparam int NREQ_MAX = 8;

  // Response record as seen by the downstream consumer
  typedef struct packed {
    logic [IDW_DEF-1:0]   id;
    logic [2*W_DEF-1:0]   product;
  } rsp_t;

  // One-hot grant of the first set bit of valid at or above ptr, wrapping within n
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] valid,
    input logic [2:0]          ptr,
    input int                  n
  );
    logic [NREQ_MAX-1:0] grant;
    logic                found;
    int                  idx;
    logic [2:0]          sel;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        sel = 3'(idx);
        if (!found && valid[sel]) begin
          grant[sel] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - stateless signed radix-2 Booth multiplier core
module booth_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] acc;
  logic           prev;

  // Recode each multiplier bit pair into add, subtract or skip of the shifted multiplicand
  always_comb begin
    a_ext = {{W{multiplicand[W-1]}}, multiplicand};
    acc   = '0;
    prev  = 1'b0;
    for (int i = 0; i < W; i++) begin
      case ({multiplier[i], prev})
        2'b10:   acc = acc - (a_ext << i);
        2'b01:   acc = acc + (a_ext << i);
        default: acc = acc;
      endcase
      prev = multiplier[i];
    end
    product = acc;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NREQ-way round-robin pick with its rotating priority pointer
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      ptr_nxt;
  logic [NREQ_MAX-1:0] req_ext;
  logic [2:0]          ptr_ext;

  // Widen request and pointer to the package function's fixed width, then pick
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    ptr_ext             = '0;
    ptr_ext[IDW-1:0]    = ptr;
    grant               = NREQ'(rr_pick(req_ext, ptr_ext, NREQ));
    idx                 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) idx = IDW'(i);
    end
  end

  assign ptr_nxt = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);

  // Pointer moves just past the winner only when a grant is actually taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && (|grant)) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin shared multiplier with issue and result registers
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_product
);

  logic            s1_v;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic [IDW-1:0]  s1_id;
  logic            s2_v;
  logic [2*W-1:0]  s2_prod;
  logic [IDW-1:0]  s2_id;

  logic            s2_load;
  logic            s1_free;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [2*W-1:0]  core_prod;

  assign s2_load = s1_v & (~s2_v | rsp_ready);
  assign s1_free = ~s1_v | s2_load;

  // Requesters see no ready while reset is held, even though S1 reads as free
  assign req_ready = grant & {NREQ{s1_free & ~rst}};
  assign accept    = s1_free & (|grant);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .adv   (s1_free),
    .grant (grant),
    .idx   (gidx)
  );

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  booth_mult #(
    .W (W)
  ) u_core (
    .multiplicand (s1_a),
    .multiplier   (s1_b),
    .product      (core_prod)
  );

  // Issue register: load on accept, empty when its item moves to S2 with nothing behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else if (accept) begin
      s1_v  <= 1'b1;
      s1_a  <= sel_a;
      s1_b  <= sel_b;
      s1_id <= gidx;
    end else if (s2_load) begin
      s1_v  <= 1'b0;
    end
  end

  // Result register: capture the core output, hold it until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_prod <= '0;
      s2_id   <= '0;
    end else if (s2_load) begin
      s2_v    <= 1'b1;
      s2_prod <= core_prod;
      s2_id   <= s1_id;
    end else if (rsp_ready) begin
      s2_v    <= 1'b0;
    end
  end

  assign rsp_valid   = s2_v;
  assign rsp_product = s2_prod;
  assign rsp_id      = s2_id;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - self-checking bench for mult_share_arb
module tb_mult_share_arb;
  import mult_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_product;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t sb_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock: scoreboard pop/push at the falling edge, return 1 unit after the rising edge
  task automatic step();
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin : pop_blk
      rsp_t e;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_product", 32'(rsp_product), 32'(e.product));
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin : push_blk
        logic signed [W-1:0]   ta;
        logic signed [W-1:0]   tb2;
        logic signed [2*W-1:0] p;
        rsp_t                  e;
        ta        = req_a[i*W +: W];
        tb2       = req_b[i*W +: W];
        p         = ta * tb2;
        e.id      = IDW'(i);
        e.product = p;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    sb_q.delete();
    step();
    rst = 1'b0;
  endtask

  initial begin : main
    int   ord[5];
    int   r;
    logic got;

    vecs[0] = '{4'h8, 4'h8, 8'h40};
    vecs[1] = '{4'h8, 4'h7, 8'hC8};
    vecs[2] = '{4'h7, 4'h7, 8'h31};
    vecs[3] = '{4'h0, 4'hB, 8'h00};
    vecs[4] = '{4'h3, 4'hE, 8'hFA};
    vecs[5] = '{4'hF, 4'hF, 8'h01};
    vecs[6] = '{4'h9, 4'h5, 8'hDD};
    vecs[7] = '{4'h4, 4'h8, 8'hE0};
    ord     = '{0, 1, 2, 3, 0};

    // reset state, with every requester asking
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = 16'h5A3C;
    req_b     = 16'h1234;
    #1 rst = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_product", 32'(rsp_product), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = '0;
    rst       = 1'b0;

    // single requester 3 * -2
    set_op(0, 4'h3, 4'hE);
    req_valid = 4'b0001;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_product", 32'(rsp_product), 32'hFA);
    chk("single_id", 32'(rsp_id), 32'd0);
    step();
    chk("single_drained", 32'(rsp_valid), 32'd0);

    // all requesters valid continuously
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'(-(i + 2)));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << ord[c]));
      if (c >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(rsp_id), 32'(ord[c-2]));
      end
      step();
    end
    req_valid = '0;
    #1 chk("rr_rsp_id_tail0", 32'(rsp_id), 32'(ord[3]));
    step();
    chk("rr_rsp_valid_tail", 32'(rsp_valid), 32'd1);
    chk("rr_rsp_id_tail1", 32'(rsp_id), 32'(ord[4]));
    step();
    step();

    // backpressure with requesters 1 and 2 (pointer sits at 1)
    rsp_ready = 1'b0;
    set_op(1, 4'h5, 4'hD);
    set_op(2, 4'hC, 4'h6);
    req_valid = 4'b0110;
    #1 chk("bp_ready1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0100;
    #1 chk("bp_ready2", 32'(req_ready), 32'b0100);
    step();
    set_op(0, 4'h6, 4'hB);
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_block", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_product", 32'(rsp_product), 32'hF1);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    #1;
    chk("bp_out2_id", 32'(rsp_id), 32'd2);
    chk("bp_out2_product", 32'(rsp_product), 32'hE8);
    step();
    chk("bp_out3_id", 32'(rsp_id), 32'd0);
    chk("bp_out3_product", 32'(rsp_product), 32'hE2);
    step();
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // corner table, one requester at a time
    for (int k = 0; k < 8; k++) begin
      r = k % NREQ;
      set_op(r, vecs[k].a, vecs[k].b);
      req_valid = 4'(1 << r);
      #1 chk("corner_ready", 32'(req_ready), 32'(1 << r));
      step();
      req_valid = '0;
      step();
      chk("corner_valid", 32'(rsp_valid), 32'd1);
      chk("corner_id", 32'(rsp_id), 32'(r));
      chk("corner_product", 32'(rsp_product), 32'(vecs[k].exp));
      step();
    end

    // exhaustive sweep with random backpressure, checked by the scoreboard
    for (int k = 0; k < 256; k++) begin
      r = k % NREQ;
      set_op(r, 4'(k >> 4), 4'(k));
      req_valid = 4'(1 << r);
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        got = req_ready[r];
        step();
      end
      chk("sweep_accept", 32'(got), 32'd1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    step();
    chk("sweep_sb_empty", 32'(sb_q.size()), 32'd0);

    // reset while both stages hold work
    rsp_ready = 1'b0;
    set_op(2, 4'h2, 4'h3);
    set_op(3, 4'h7, 4'h9);
    req_valid = 4'b1100;
    step();
    step();
    #1;
    chk("midrst_full", 32'(rsp_valid), 32'd1);
    chk("midrst_block", 32'(req_ready), 32'd0);
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_product", 32'(rsp_product), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1 chk("midrst_first_grant", 32'(req_ready), 32'b0100);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
    step();

    // pointer wrap from 3 back to 0
    reset_pulse();
    rsp_ready = 1'b1;
    set_op(3, 4'h2, 4'h3);
    set_op(0, 4'hF, 4'h4);
    req_valid = 4'b1000;
    #1 chk("wrap_first", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1001;
    #1 chk("wrap_next", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    step();
    step();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
